// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with mid-bit sampling, feeding a small circular FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLK_FREQ       = 125_000_000,
  parameter int BAUD           = 115_200,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       rd_en_i,
  output logic [7:0] data_o,
  output logic       fifo_empty_o,
  output logic       fifo_full_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // state     | meaning
  // IDLE      | line idle, waiting for a low level
  // START     | half-bit wait, confirm start bit at its centre
  // DATA      | sample 8 data bits LSB first at bit centres
  // STOP      | sample stop bit; high writes the byte, low flags a framing error
  // WAIT_IDLE | after a framing error, wait for the line to return high

  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int AW          = FIFO_ADDR_BITS;
  localparam int DEPTH       = 2 ** FIFO_ADDR_BITS;

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             wr_en;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mem_q [DEPTH];
  logic             empty, full;
  logic             do_read, do_write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    wr_en       = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            cnt_d   = BIT_LOAD;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = BIT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            wr_en   = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A read while full frees the slot the concurrent write lands in.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_read   = rd_en_i && !empty;
    do_write  = wr_en && (!full || do_read);
    overrun_d = wr_en && full && !do_read;
    wr_ptr_d  = do_write ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_read ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    data_d    = data_q;
    if (rd_ptr_d != wr_ptr_d) begin
      if (do_write && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        data_d = shift_q;
      end else begin
        data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= 8'h00;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign data_o       = data_q;
  assign fifo_empty_o = empty;
  assign fifo_full_o  = full;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit with a 4-entry FIFO; expected bytes
// and error pulses come from a queue-based model of the received stream.
module tb_uart_rx;
  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int FAB      = 2;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] data;
  logic       empty, full, ferr, ovr;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_ADDR_BITS(FAB)) u_dut (
    .clk(clk), .rst(rst), .rx_i(rx), .rd_en_i(rd_en),
    .data_o(data), .fifo_empty_o(empty), .fifo_full_o(full),
    .frame_err_o(ferr), .overrun_o(ovr)
  );

  // Every high cycle counts, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stop bit is sampled on the 155th edge after the start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit chk_lat,
                            input bit rd_at_stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      tick(16);
    end
    rx = bits[9];
    tick(10);
    if (chk_lat) check("pre_stop_empty", empty, 1);
    if (rd_at_stop) begin
      check("rd_at_stop_head", data, exp_q[0]);
      last_rd = exp_q.pop_front();
      rd_en = 1'b1;
    end
    tick(1);
    rd_en = 1'b0;
    if (chk_lat) begin
      check("lat_data", data, b);
      check("lat_empty", empty, 0);
    end
    tick(5);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int hold,
                       input bit chk_lat, input bit rd_at_stop);
    send_frame(b, stop, chk_lat, rd_at_stop);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr++;
    end else begin
      exp_ferr++;
      tick(hold);
      rx = 1'b1;
      tick(6);
    end
    check("ferr_count", ferr_cnt, exp_ferr);
    check("ovr_count", ovr_cnt, exp_ovr);
    check("empty_flag", empty, exp_q.size() == 0);
    check("full_flag", full, exp_q.size() == DEPTH);
  endtask

  task automatic pop_one();
    check("pop_data", data, exp_q[0]);
    last_rd = exp_q.pop_front();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    check("drained_empty", empty, 1);
    check("hold_data", data, last_rd);
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         npop;

    rst = 1'b1;
    rx = 1'b1;
    rd_en = 1'b0;
    last_rd = 8'h00;
    tick(5);
    check("rst_data", data, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    rst = 1'b0;
    tick(3);

    // Good frame with exact write latency.
    frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    drain();

    // Reads on an empty FIFO are ignored.
    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    check("rd_empty_flag", empty, 1);
    check("rd_empty_data", data, last_rd);

    // Short glitch is rejected, then a real frame.
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("glitch_empty", empty, 1);
    check("glitch_ferr", ferr_cnt, exp_ferr);
    frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
    drain();

    // Framing error followed by a held break: one pulse only.
    frame(8'h55, 1'b0, 40, 1'b0, 1'b0);
    frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
    drain();

    // Overflow drops the fifth byte.
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 0, 1'b0, 1'b0);
    drain();

    // Read coinciding with the fifth write while full.
    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1, 0, 1'b0, 1'b0);
    frame(8'h05, 1'b1, 0, 1'b0, 1'b1);
    check("full_kept", full, 1);
    drain();

    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      frame(b, stop, int'($urandom_range(16, 48)), 1'b0, 1'b0);
      npop = int'($urandom_range(0, exp_q.size()));
      for (int j = 0; j < npop; j++) pop_one();
    end
    drain();

    // Reset in the middle of data bit 3 of 0xF0 with a byte already queued.
    frame(8'h7E, 1'b1, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0;
      tick(16);
    end
    rx = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(2);
    check("midrst_data", data, 8'h00);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovr", ovr, 0);
    tick(6);
    rx = 1'b1;
    tick(4);
    rst = 1'b0;
    exp_q.delete();
    last_rd = 8'h00;
    tick(120);
    check("postrst_empty", empty, 1);
    check("postrst_data", data, 8'h00);
    check("postrst_ferr", ferr_cnt, exp_ferr);
    check("postrst_ovr", ovr_cnt, exp_ovr);

    frame(8'hC3, 1'b1, 0, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
